// File: rtl/ov7670_frame_writer.sv
// OV7670 capture stage: pairs camera bytes into RGB565 pixels and writes them
// into the 320x240 frame buffer at y*H_RES + x, pulsing frame_done per frame.
module ov7670_frame_writer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  cam_data,
  output logic        we,
  output logic [16:0] wAddr,
  output logic [15:0] wData,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    SYNC_WAIT,
    VBLANK,
    ACTIVE
  } state_t;

  localparam logic [8:0] H_MAX = 9'(H_RES);
  localparam logic [7:0] V_MAX = 8'(V_RES);

  state_t      r_state;
  logic [8:0]  r_hCnt;
  logic [7:0]  r_vCnt;
  logic        r_ph;
  logic [7:0]  r_hi;
  logic        r_hrefD;
  logic        r_we;
  logic [16:0] r_wAddr;
  logic [15:0] r_wData;
  logic        r_frameDone;
  logic [16:0] w_addr;

  assign w_addr     = 17'(r_vCnt) * 17'(H_RES) + 17'(r_hCnt);
  assign we         = r_we;
  assign wAddr      = r_wAddr;
  assign wData      = r_wData;
  assign frame_done = r_frameDone;

  // vsync has priority over line end and pixel completion, so a frame cut
  // short mid-pixel never emits that pixel.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state     <= SYNC_WAIT;
      r_hCnt      <= '0;
      r_vCnt      <= '0;
      r_ph        <= 1'b0;
      r_hi        <= '0;
      r_hrefD     <= 1'b0;
      r_we        <= 1'b0;
      r_wAddr     <= '0;
      r_wData     <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_frameDone <= 1'b0;
      case (r_state)
        SYNC_WAIT: begin
          r_hrefD <= 1'b0;
          if (vsync) r_state <= VBLANK;
        end
        VBLANK: begin
          r_hrefD <= 1'b0;
          if (!vsync) begin
            r_state <= ACTIVE;
            r_hCnt  <= '0;
            r_vCnt  <= '0;
            r_ph    <= 1'b0;
          end
        end
        ACTIVE: begin
          r_hrefD <= href;
          if (vsync) begin
            r_state     <= VBLANK;
            r_frameDone <= 1'b1;
          end else if (r_hrefD && !href) begin
            r_hCnt <= '0;
            r_ph   <= 1'b0;
            if (r_vCnt < V_MAX) r_vCnt <= r_vCnt + 8'd1;
          end else if (href) begin
            r_ph <= ~r_ph;
            if (!r_ph) begin
              r_hi <= cam_data;
            end else if (r_hCnt < H_MAX) begin
              r_hCnt <= r_hCnt + 9'd1;
              if (r_vCnt < V_MAX) begin
                r_we    <= 1'b1;
                r_wAddr <= w_addr;
                r_wData <= {r_hi, cam_data};
              end
            end
          end
        end
        default: r_state <= SYNC_WAIT;
      endcase
    end
  end

endmodule
